// File: rtl/uart_frame_unpack.sv
// ---------------------------------------------------------------------------
// uart_frame_unpack
//
// Receive-side assembler for the inter-board score link. It rebuilds 4-byte
// score frames from the UART RX byte stream. Each frame is the board ID,
// then points[23:16], points[15:8] and points[7:0]. When a frame completes,
// the board ID and the 24-bit points are published as registered outputs.
// The block also tracks whether the far end is alive.
//
// Parameters
//   TIMEOUT_CYCLES : max idle cycles between bytes inside a frame (>= 2)
//   IDLE_BYTE      : byte the far end sends when it has no board ID
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   rx_data[7:0] in   received byte, qualified by rx_done
//   rx_done      in   one-cycle strobe per received byte
//   rem_board_ID out  board ID of the last complete frame
//   rem_points   out  24-bit points of the last complete frame
//   frame_valid  out  one-cycle pulse when rem_* update
//   link_up      out  level, far end is sending valid frames
//   resync       out  one-cycle pulse when a partial frame is dropped
// ---------------------------------------------------------------------------
module uart_frame_unpack #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  IDLE_BYTE      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  rem_board_ID,
  output logic [23:0] rem_points,
  output logic        frame_valid,
  output logic        link_up,
  output logic        resync
);

  localparam int            CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_ID,
    WAIT_P2,
    WAIT_P1,
    WAIT_P0
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           idShadow_q, idShadow_d;
  logic [23:0]          ptsShadow_q, ptsShadow_d;
  logic [CntWidth-1:0]  idleCnt_q, idleCnt_d;
  logic [7:0]           remId_q, remId_d;
  logic [23:0]          remPts_q, remPts_d;
  logic                 frameValid_q, frameValid_d;
  logic                 linkUp_q, linkUp_d;
  logic                 resync_q, resync_d;
  logic                 timeout;

  // The counter only means something inside a frame. It holds at zero in
  // WAIT_ID and restarts on every byte. On reaching CntMax it holds there
  // instead of wrapping.
  always_comb begin
    idleCnt_d = idleCnt_q;
    if (state_q == WAIT_ID || rx_done) begin
      idleCnt_d = '0;
    end else if (idleCnt_q != CntMax) begin
      idleCnt_d = idleCnt_q + CntWidth'(1);
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout = (idleCnt_q == CntMax) && !rx_done;

  // Next-state and output logic. The shadow registers collect the frame in
  // progress. rem_* are loaded only when the last byte arrives, so a
  // partial frame never reaches the outputs.
  always_comb begin
    state_d      = state_q;
    idShadow_d   = idShadow_q;
    ptsShadow_d  = ptsShadow_q;
    remId_d      = remId_q;
    remPts_d     = remPts_q;
    frameValid_d = 1'b0;
    linkUp_d     = linkUp_q;
    resync_d     = 1'b0;

    unique case (state_q)
      WAIT_ID: begin
        if (rx_done) begin
          if (rx_data == IDLE_BYTE) begin
            linkUp_d = 1'b0;
          end else if (rx_data != 8'h00) begin
            idShadow_d = rx_data;
            state_d    = WAIT_P2;
          end
        end
      end

      WAIT_P2: begin
        if (rx_done) begin
          ptsShadow_d[23:16] = rx_data;
          state_d            = WAIT_P1;
        end else if (timeout) begin
          state_d  = WAIT_ID;
          resync_d = 1'b1;
          linkUp_d = 1'b0;
        end
      end

      WAIT_P1: begin
        if (rx_done) begin
          ptsShadow_d[15:8] = rx_data;
          state_d           = WAIT_P0;
        end else if (timeout) begin
          state_d  = WAIT_ID;
          resync_d = 1'b1;
          linkUp_d = 1'b0;
        end
      end

      WAIT_P0: begin
        if (rx_done) begin
          // Take the last byte straight from rx_data. Going through the
          // shadow would add a cycle of latency.
          ptsShadow_d[7:0] = rx_data;
          remId_d          = idShadow_q;
          remPts_d         = {ptsShadow_q[23:8], rx_data};
          frameValid_d     = 1'b1;
          linkUp_d         = 1'b1;
          state_d          = WAIT_ID;
        end else if (timeout) begin
          state_d  = WAIT_ID;
          resync_d = 1'b1;
          linkUp_d = 1'b0;
        end
      end

      default: begin
        state_d = WAIT_ID;
      end
    endcase
  end

  // State and output registers. Reset drops any partial frame immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_ID;
      idShadow_q   <= '0;
      ptsShadow_q  <= '0;
      idleCnt_q    <= '0;
      remId_q      <= '0;
      remPts_q     <= '0;
      frameValid_q <= 1'b0;
      linkUp_q     <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idShadow_q   <= idShadow_d;
      ptsShadow_q  <= ptsShadow_d;
      idleCnt_q    <= idleCnt_d;
      remId_q      <= remId_d;
      remPts_q     <= remPts_d;
      frameValid_q <= frameValid_d;
      linkUp_q     <= linkUp_d;
      resync_q     <= resync_d;
    end
  end

  assign rem_board_ID = remId_q;
  assign rem_points   = remPts_q;
  assign frame_valid  = frameValid_q;
  assign link_up      = linkUp_q;
  assign resync       = resync_q;

endmodule

// File: tb/tb_uart_frame_unpack.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_unpack
//
// Self-checking bench for uart_frame_unpack, with TIMEOUT_CYCLES = 50.
// A reference model built from a byte queue and edge timestamps predicts
// every output after every clock edge. Directed scenarios run first,
// followed by a randomized byte stream with random gaps and resets.
// ---------------------------------------------------------------------------
module tb_uart_frame_unpack;

  localparam int T = 50;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  rem_board_ID;
  logic [23:0] rem_points;
  logic        frame_valid;
  logic        link_up;
  logic        resync;

  int checks = 0;
  int errors = 0;

  // Reference model state. The partial frame is a queue of received bytes.
  // lastEdge records the edge index at which the latest byte arrived.
  logic [7:0]  partial[$];
  int          edgeCnt  = 0;
  int          lastEdge = 0;
  logic [7:0]  expId    = '0;
  logic [23:0] expPts   = '0;
  logic        expFv    = 1'b0;
  logic        expLink  = 1'b0;
  logic        expResync = 1'b0;

  uart_frame_unpack #(
    .TIMEOUT_CYCLES(T),
    .IDLE_BYTE     (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rem_board_ID(rem_board_ID),
    .rem_points  (rem_points),
    .frame_valid (frame_valid),
    .link_up     (link_up),
    .resync      (resync)
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".id"},     {24'd0, rem_board_ID}, {24'd0, expId});
    checkOutput({tag, ".pts"},    {8'd0, rem_points},    {8'd0, expPts});
    checkOutput({tag, ".fv"},     {31'd0, frame_valid},  {31'd0, expFv});
    checkOutput({tag, ".link"},   {31'd0, link_up},      {31'd0, expLink});
    checkOutput({tag, ".resync"}, {31'd0, resync},       {31'd0, expResync});
  endtask

  // Applies the frame rules to one clock edge. A frame is four bytes
  // collected in a queue. A gap of more than T idle edges after a byte
  // drops the partial frame.
  task automatic stepModel(input logic valid, input logic [7:0] data);
    edgeCnt++;
    expFv     = 1'b0;
    expResync = 1'b0;
    if (valid) begin
      if (partial.size() == 0) begin
        if (data == 8'hFF) begin
          expLink = 1'b0;
        end else if (data != 8'h00) begin
          partial.push_back(data);
          lastEdge = edgeCnt;
        end
      end else begin
        partial.push_back(data);
        lastEdge = edgeCnt;
        if (partial.size() == 4) begin
          expId   = partial[0];
          expPts  = {partial[1], partial[2], partial[3]};
          expFv   = 1'b1;
          expLink = 1'b1;
          partial.delete();
        end
      end
    end else if (partial.size() != 0 && (edgeCnt - lastEdge) == T + 1) begin
      partial.delete();
      expResync = 1'b1;
      expLink   = 1'b0;
    end
  endtask

  // Drives one cycle of input, advances the model at the edge and checks
  // the outputs 1 time unit later. Idle cycles carry junk on rx_data.
  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input string tag);
    rx_done = valid;
    rx_data = valid ? data : 8'($urandom);
    @(posedge clk);
    stepModel(valid, data);
    #1;
    checkAll(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, tag);
  endtask

  // Asserts reset away from the clock edge. Outputs must clear before any
  // further edge occurs.
  task automatic doReset();
    rst     = 1'b0;
    rx_done = 1'b0;
    #2;
    partial.delete();
    expId = '0; expPts = '0; expFv = 1'b0; expLink = 1'b0; expResync = 1'b0;
    checkAll("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int gap, input string tag);
    logic [7:0] bytes [4];
    bytes = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bytes[i], tag);
      idleCycles(gap, tag);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    int         gap;
    rst     = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    #3;
    doReset();

    // Slow frame, bytes 20 cycles apart
    sendBytes(8'h03, 8'h01, 8'h86, 8'hA0, 19, "slow");

    // Two frames back to back with no dead cycles
    sendBytes(8'h05, 8'h00, 8'h00, 8'h07, 0, "b2b1");
    sendBytes(8'h05, 8'h00, 8'h00, 8'h08, 0, "b2b2");
    idleCycles(3, "b2bidle");

    // Idle byte drops link, zero byte ignored, payload FF/00 is data
    applyStimulus(1'b1, 8'hFF, "idlebyte");
    applyStimulus(1'b1, 8'h00, "zerobyte");
    sendBytes(8'h02, 8'hFF, 8'h00, 8'hFF, 1, "payload");

    // Timeout after two bytes, then recovery
    applyStimulus(1'b1, 8'h04, "to");
    applyStimulus(1'b1, 8'h12, "to");
    idleCycles(60, "tosilence");
    sendBytes(8'h04, 8'h00, 8'h00, 8'h2A, 0, "torecover");

    // Byte arrives exactly in the expiry cycle and must win
    applyStimulus(1'b1, 8'h09, "expiry");
    idleCycles(T, "expirywait");
    applyStimulus(1'b1, 8'h00, "expirybyte");
    sendBytes(8'h00, 8'h01, 8'hFF, 8'hFF, 0, "expiryrest");
    idleCycles(2, "expiryidle");

    // Reset mid-frame; the two remaining bytes must not complete a frame
    sendBytes(8'h03, 8'h01, 8'h86, 8'hA0, 0, "prefill");
    applyStimulus(1'b1, 8'h07, "midrst");
    applyStimulus(1'b1, 8'h11, "midrst");
    doReset();
    applyStimulus(1'b1, 8'h86, "afterrst");
    applyStimulus(1'b1, 8'hA0, "afterrst");
    idleCycles(5, "afterrst");

    // Randomized byte stream with gaps around the timeout boundary
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 15));
      b = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      applyStimulus(1'b1, b, "rand");
      r = int'($urandom_range(0, 9));
      if (r < 5)       gap = 0;
      else if (r < 8)  gap = int'($urandom_range(1, 6));
      else             gap = int'($urandom_range(T - 2, T + 3));
      idleCycles(gap, "randgap");
      if ($urandom_range(0, 99) == 0) doReset();
    end
    idleCycles(T + 5, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
